// File: rtl/seg_codes_pkg.sv
// Shared constants for the 7-segment read-back path: segment patterns (dp+gfedcba),
// the special blank/error codes and the capture FSM state type.
package seg_codes_pkg;

  localparam logic [6:0] CODE_BLANK = 7'h7E;
  localparam logic [6:0] CODE_ERR   = 7'h7F;

  localparam logic [7:0] PAT_BLANK = 8'h00;

  localparam logic [7:0] PAT_0 = 8'h3F;
  localparam logic [7:0] PAT_1 = 8'h06;
  localparam logic [7:0] PAT_2 = 8'h5B;
  localparam logic [7:0] PAT_3 = 8'h4F;
  localparam logic [7:0] PAT_4 = 8'h66;
  localparam logic [7:0] PAT_5 = 8'h6D;
  localparam logic [7:0] PAT_6 = 8'h7D;
  localparam logic [7:0] PAT_7 = 8'h07;
  localparam logic [7:0] PAT_8 = 8'h7F;
  localparam logic [7:0] PAT_9 = 8'h6F;
  localparam logic [7:0] PAT_A = 8'h77;
  localparam logic [7:0] PAT_B = 8'h7C;
  localparam logic [7:0] PAT_C = 8'h39;
  localparam logic [7:0] PAT_D = 8'h5E;
  localparam logic [7:0] PAT_E = 8'h79;
  localparam logic [7:0] PAT_F = 8'h71;

  // Decimal digits with the decimal point lit decode to codes 20..29.
  localparam logic [7:0] PAT_DP0 = 8'hBF;
  localparam logic [7:0] PAT_DP1 = 8'h86;
  localparam logic [7:0] PAT_DP2 = 8'hDB;
  localparam logic [7:0] PAT_DP3 = 8'hCF;
  localparam logic [7:0] PAT_DP4 = 8'hE6;
  localparam logic [7:0] PAT_DP5 = 8'hED;
  localparam logic [7:0] PAT_DP6 = 8'hFD;
  localparam logic [7:0] PAT_DP7 = 8'h87;
  localparam logic [7:0] PAT_DP8 = 8'hFF;
  localparam logic [7:0] PAT_DP9 = 8'hEF;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    CAPTURED
  } state_t;

endpackage

// File: rtl/seg_pat_dec.sv
// Combinational inverse of the segment encoder: 8-bit lit pattern to 7-bit digit code.
// Unrecognised patterns yield CODE_ERR with err raised.
module seg_pat_dec
  import seg_codes_pkg::*;
(
  input  logic [7:0] pat,
  output logic [6:0] code,
  output logic       err
);

  logic hit;

  always_comb begin
    code = CODE_ERR;
    hit  = 1'b1;
    case (pat)
      PAT_BLANK: code = CODE_BLANK;
      PAT_0:     code = 7'd0;
      PAT_1:     code = 7'd1;
      PAT_2:     code = 7'd2;
      PAT_3:     code = 7'd3;
      PAT_4:     code = 7'd4;
      PAT_5:     code = 7'd5;
      PAT_6:     code = 7'd6;
      PAT_7:     code = 7'd7;
      PAT_8:     code = 7'd8;
      PAT_9:     code = 7'd9;
      PAT_A:     code = 7'd10;
      PAT_B:     code = 7'd11;
      PAT_C:     code = 7'd12;
      PAT_D:     code = 7'd13;
      PAT_E:     code = 7'd14;
      PAT_F:     code = 7'd15;
      PAT_DP0:   code = 7'd20;
      PAT_DP1:   code = 7'd21;
      PAT_DP2:   code = 7'd22;
      PAT_DP3:   code = 7'd23;
      PAT_DP4:   code = 7'd24;
      PAT_DP5:   code = 7'd25;
      PAT_DP6:   code = 7'd26;
      PAT_DP7:   code = 7'd27;
      PAT_DP8:   code = 7'd28;
      PAT_DP9:   code = 7'd29;
      default: begin
        code = CODE_ERR;
        hit  = 1'b0;
      end
    endcase
    err = ~hit;
  end

endmodule

// File: rtl/seg_capture.sv
// Reader side of a multiplexed 7-segment interface: synchronises the scanned bus, waits
// for a stable pattern on a single selected digit, then stores its decoded code per slot.
module seg_capture
  import seg_codes_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            SEG_IN,
  input  logic [NDIG-1:0]       COM_IN,
  input  logic                  ERR_CLR,
  output logic [7*NDIG-1:0]     DIGITS_OUT,
  output logic                  UPD_VALID,
  output logic [IDX_W-1:0]      UPD_IDX,
  output logic                  ERR_FLAG,
  output state_t                FSM_STATE
);

  logic [7:0]      m_seg, s_seg, p_seg;
  logic [NDIG-1:0] m_com, s_com, p_com;
  logic [CNT_W-1:0] run_cnt, run_cur;
  logic            same;
  logic            com_onehot;
  logic [IDX_W-1:0] com_idx;
  logic [6:0]      dec_code;
  logic            dec_err;
  logic            cap;
  state_t          state, state_nxt;
  logic [6:0]      slot [NDIG];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_seg   <= '0;
      s_seg   <= '0;
      p_seg   <= '0;
      m_com   <= '0;
      s_com   <= '0;
      p_com   <= '0;
      run_cnt <= '0;
    end else begin
      m_seg   <= SEG_IN;
      s_seg   <= m_seg;
      p_seg   <= s_seg;
      m_com   <= COM_IN;
      s_com   <= m_com;
      p_com   <= s_com;
      run_cnt <= run_cur;
    end
  end

  // run_cur is the run length including the current synchronised sample.
  assign same = (s_seg == p_seg) && (s_com == p_com);

  always_comb begin
    run_cur = CNT_W'(1);
    if (same) begin
      if (run_cnt >= CNT_W'(STABLE_CNT)) run_cur = CNT_W'(STABLE_CNT);
      else                               run_cur = run_cnt + CNT_W'(1);
    end
  end

  assign com_onehot = (s_com != '0) && ((s_com & (s_com - NDIG'(1))) == '0);

  always_comb begin
    com_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (s_com[i]) com_idx = com_idx | IDX_W'(i);
    end
  end

  seg_pat_dec u_dec (
    .pat  (s_seg),
    .code (dec_code),
    .err  (dec_err)
  );

  assign cap = (state == TRACK) && com_onehot && (run_cur == CNT_W'(STABLE_CNT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (com_onehot) state_nxt = TRACK;
      TRACK: begin
        if (!com_onehot) state_nxt = IDLE;
        else if (cap)    state_nxt = CAPTURED;
      end
      CAPTURED: if (!same) state_nxt = com_onehot ? TRACK : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign FSM_STATE = state;

  // Error set takes priority over a coincident clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NDIG; i++) slot[i] <= CODE_BLANK;
      UPD_VALID <= 1'b0;
      UPD_IDX   <= '0;
      ERR_FLAG  <= 1'b0;
    end else begin
      UPD_VALID <= cap;
      if (cap) begin
        slot[com_idx] <= dec_code;
        UPD_IDX       <= com_idx;
      end
      if (cap && dec_err) ERR_FLAG <= 1'b1;
      else if (ERR_CLR)   ERR_FLAG <= 1'b0;
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_out
    assign DIGITS_OUT[7*g +: 7] = slot[g];
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed and randomized checks of seg_capture against a sample-history reference model:
// a slot write lands two edges after a one-hot run of identical samples reaches STABLE.
module tb_seg_capture;
  import seg_codes_pkg::*;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  localparam logic [7:0] HEX_PAT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam logic [7:0] SCAN_PAT [4] = '{8'hED, 8'h7C, 8'h00, 8'hFF};

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [7:0]           SEG_IN = '0;
  logic [NDIG-1:0]      COM_IN = '0;
  logic                 ERR_CLR = 1'b0;
  logic [7*NDIG-1:0]    DIGITS_OUT;
  logic                 UPD_VALID;
  logic [1:0]           UPD_IDX;
  logic                 ERR_FLAG;
  state_t               FSM_STATE;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]      h_seg [$];
  logic [NDIG-1:0] h_com [$];
  logic [6:0]      exp_slot [NDIG];
  logic            exp_valid;
  logic            exp_err;
  logic [8:0]      exp_q [$];
  int              pulses;
  logic [1:0]      pulse_idx [$];

  always #5 CLK = ~CLK;

  seg_capture #(
    .NDIG       (NDIG),
    .STABLE_CNT (STABLE),
    .CNT_W      (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SEG_IN     (SEG_IN),
    .COM_IN     (COM_IN),
    .ERR_CLR    (ERR_CLR),
    .DIGITS_OUT (DIGITS_OUT),
    .UPD_VALID  (UPD_VALID),
    .UPD_IDX    (UPD_IDX),
    .ERR_FLAG   (ERR_FLAG),
    .FSM_STATE  (FSM_STATE)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Returns {err, code} straight from the pattern table.
  function automatic logic [7:0] ref_decode(input logic [7:0] p);
    if (p == 8'h00) return {1'b0, 7'h7E};
    for (int i = 0; i < 16; i++) begin
      if (p == HEX_PAT[i]) return {1'b0, 7'(i)};
      if (i < 10 && p == (HEX_PAT[i] | 8'h80)) return {1'b0, 7'(20 + i)};
    end
    return {1'b1, 7'h7F};
  endfunction

  task automatic model_reset();
    h_seg.delete();
    h_com.delete();
    repeat (STABLE + 3) begin
      h_seg.push_back(8'h00);
      h_com.push_back('0);
    end
    for (int i = 0; i < NDIG; i++) exp_slot[i] = 7'h7E;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_q.delete();
  endtask

  // History holds samples from edges k-2-STABLE .. k after this push.
  task automatic model_edge();
    logic       wr;
    logic [7:0] d;
    logic [1:0] idx;
    d   = '0;
    idx = '0;
    h_seg.push_back(SEG_IN);
    h_com.push_back(COM_IN);
    void'(h_seg.pop_front());
    void'(h_com.pop_front());
    wr = $onehot(h_com[1]) && ((h_seg[0] !== h_seg[1]) || (h_com[0] !== h_com[1]));
    for (int i = 2; i <= STABLE; i++)
      if ((h_seg[i] !== h_seg[1]) || (h_com[i] !== h_com[1])) wr = 1'b0;
    exp_valid = wr;
    if (wr) begin
      d   = ref_decode(h_seg[1]);
      idx = 2'($clog2(h_com[1]));
      exp_slot[idx] = d[6:0];
      exp_q.push_back({idx, d[6:0]});
    end
    if (wr && d[7]) exp_err = 1'b1;
    else if (ERR_CLR) exp_err = 1'b0;
  endtask

  task automatic check_outputs();
    logic [8:0] e;
    chk("upd_valid", UPD_VALID, exp_valid);
    chk("err_flag", ERR_FLAG, exp_err);
    for (int i = 0; i < NDIG; i++) chk("slot", DIGITS_OUT[7*i +: 7], exp_slot[i]);
    if (UPD_VALID) begin
      pulses++;
      pulse_idx.push_back(UPD_IDX);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("upd_idx", UPD_IDX, e[8:7]);
      chk("upd_code", DIGITS_OUT[7*e[8:7] +: 7], e[6:0]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!UPD_VALID && n < limit);
  endtask

  initial begin
    int         lat;
    logic [7:0] p;
    int         r;
    logic [31:0] got;

    model_reset();

    // Reset values
    repeat (3) tick();
    chk("rst_digits", DIGITS_OUT, {NDIG{7'h7E}});
    chk("rst_upd", UPD_VALID, 1'b0);
    chk("rst_err", ERR_FLAG, 1'b0);
    chk("rst_state", FSM_STATE, IDLE);
    RST = 1'b0;
    SEG_IN = 8'h3F;
    COM_IN = '0;
    pulses = 0;
    repeat (20) tick();
    chk("no_com_no_pulse", pulses, 0);

    // Latency
    SEG_IN = 8'h5B;
    COM_IN = 4'b0010;
    wait_pulse(20, lat);
    chk("latency_edges", lat, 6);
    chk("latency_idx", UPD_IDX, 2'd1);
    chk("latency_slot1", DIGITS_OUT[13:7], 7'd2);
    pulses = 0;
    repeat (50) tick();
    chk("no_second_pulse", pulses, 0);

    // Full scan
    pulses = 0;
    pulse_idx.delete();
    for (int d = 0; d < 4; d++) begin
      SEG_IN = SCAN_PAT[d];
      COM_IN = NDIG'(1) << d;
      repeat (10) tick();
    end
    chk("scan_pulses", pulses, 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < pulse_idx.size()) ? 32'(pulse_idx[i]) : 32'hFFFF_FFFF;
      chk("scan_idx", got, i);
    end
    chk("scan_slot0", DIGITS_OUT[6:0], 7'd25);
    chk("scan_slot1", DIGITS_OUT[13:7], 7'd11);
    chk("scan_slot2", DIGITS_OUT[20:14], 7'h7E);
    chk("scan_slot3", DIGITS_OUT[27:21], 7'd28);

    // Glitch rejection
    COM_IN = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      SEG_IN = (i % 2 == 1) ? 8'h06 : 8'h4F;
      repeat (3) tick();
    end
    chk("glitch_no_write", pulses, 0);
    chk("glitch_slot0", DIGITS_OUT[6:0], 7'd25);
    COM_IN = 4'b0011;
    SEG_IN = 8'h66;
    pulses = 0;
    repeat (20) tick();
    chk("multi_com_no_write", pulses, 0);
    chk("multi_com_idle", FSM_STATE, IDLE);

    // Error handling
    COM_IN = 4'b1000;
    SEG_IN = 8'hF7;
    pulses = 0;
    repeat (10) tick();
    chk("err_pulses", pulses, 1);
    chk("err_slot3", DIGITS_OUT[27:21], 7'h7F);
    chk("err_set", ERR_FLAG, 1'b1);
    COM_IN = 4'b0100;
    SEG_IN = 8'hAA;
    repeat (5) tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("clr_vs_set_pulse", UPD_VALID, 1'b1);
    chk("clr_vs_set_err", ERR_FLAG, 1'b1);
    chk("err_slot2", DIGITS_OUT[20:14], 7'h7F);
    repeat (4) tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("lone_clr", ERR_FLAG, 1'b0);

    // Reset mid-capture
    COM_IN = 4'b0001;
    SEG_IN = 8'h06;
    repeat (3) tick();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_digits", DIGITS_OUT, {NDIG{7'h7E}});
    chk("mid_rst_upd", UPD_VALID, 1'b0);
    chk("mid_rst_err", ERR_FLAG, 1'b0);
    chk("mid_rst_state", FSM_STATE, IDLE);
    repeat (2) tick();
    RST = 1'b0;
    wait_pulse(20, lat);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_slot0", DIGITS_OUT[6:0], 7'd1);

    // Randomized scanning
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) COM_IN = NDIG'($urandom_range(0, 15));
      else        COM_IN = NDIG'(1) << $urandom_range(0, 3);
      if (r < 7) begin
        p = HEX_PAT[$urandom_range(0, 15)];
        if ($urandom_range(0, 2) == 0) p = p | 8'h80;
        SEG_IN = p;
      end else begin
        SEG_IN = 8'($urandom);
      end
      ERR_CLR = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 10)) tick();
    end
    ERR_CLR = 1'b0;
    repeat (10) tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
